// File: rtl/button_event_decoder.sv
// Classifies debounced button activity into press/release/short/long/double event pulses.
// Two-process FSM with a shared saturating cycle counter that restarts on every state change.
module button_event_decoder #(
  parameter bit ACTIVE_HIGH       = 1'b1,
  parameter int LONG_CYCLES       = 1000,
  parameter int DCLICK_GAP_CYCLES = 300
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_sig_debounced,
  output logic o_press,
  output logic o_release,
  output logic o_short,
  output logic o_long,
  output logic o_double,
  output logic o_held
);

  localparam int MAXC = (LONG_CYCLES > DCLICK_GAP_CYCLES) ? LONG_CYCLES : DCLICK_GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(DCLICK_GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    LONG_HELD,
    WAIT2,
    PRESS2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          p, p_q;
  logic          rise, fall;
  logic          short_nxt, long_nxt, double_nxt;

  assign p      = (i_sig_debounced == ACTIVE_HIGH);
  assign rise   = p & ~p_q;
  assign fall   = ~p & p_q;
  assign o_held = p_q;

  // Edge-qualified transitions: a release beats the long threshold, a press beats gap expiry
  always_comb begin
    state_nxt  = state;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    double_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (rise) state_nxt = PRESS1;
      end
      PRESS1: begin
        if (fall) begin
          state_nxt = WAIT2;
        end else if (cnt == LONG_LAST) begin
          state_nxt = LONG_HELD;
          long_nxt  = 1'b1;
        end
      end
      LONG_HELD: begin
        if (fall) state_nxt = IDLE;
      end
      WAIT2: begin
        if (rise) begin
          state_nxt  = PRESS2;
          double_nxt = 1'b1;
        end else if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          short_nxt = 1'b1;
        end
      end
      PRESS2: begin
        if (fall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_q       <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_short   <= 1'b0;
      o_long    <= 1'b0;
      o_double  <= 1'b0;
    end else begin
      p_q       <= p;
      state     <= state_nxt;
      o_press   <= rise;
      o_release <= fall;
      o_short   <= short_nxt;
      o_long    <= long_nxt;
      o_double  <= double_nxt;
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: active-high and active-low instances driven with the same
// pressed pattern, checked against a timestamp-based event model plus scenario tables.
module tb_button_event_decoder;

  localparam int L = 20;
  localparam int G = 10;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic sig_h = 1'b0;
  logic sig_l = 1'b1;
  logic ph, rh, sh, lh, dh, hh;
  logic pl, rl, sl, ll, dl, hl;

  always #5 clk = ~clk;

  button_event_decoder #(.ACTIVE_HIGH(1'b1), .LONG_CYCLES(L), .DCLICK_GAP_CYCLES(G)) dut_h (
    .clk(clk), .rstn(rstn), .i_sig_debounced(sig_h),
    .o_press(ph), .o_release(rh), .o_short(sh), .o_long(lh), .o_double(dh), .o_held(hh));

  button_event_decoder #(.ACTIVE_HIGH(1'b0), .LONG_CYCLES(L), .DCLICK_GAP_CYCLES(G)) dut_l (
    .clk(clk), .rstn(rstn), .i_sig_debounced(sig_l),
    .o_press(pl), .o_release(rl), .o_short(sl), .o_long(ll), .o_double(dl), .o_held(hl));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // event model state: timestamps of last press/release and what the current press may still become
  bit m_pq, m_first, m_armed, m_longdone;
  int m_tp, m_tr;
  logic [5:0] exp_v;

  // scenario statistics taken from the active-high outputs
  int t_press, t_rel, t_long, t_short, n_short, n_long, n_double;

  typedef struct {
    int h1; int gap; int h2;
    int n_short; int n_long; int n_double;
    int long_off; int short_off;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
    end
  endtask

  task automatic chk_vec(input string name, input logic [5:0] got, input logic [5:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b want=%b (press,release,short,long,double,held)",
               name, cyc, got, want);
    end
  endtask

  task automatic model_step(input bit p, input bit in_reset);
    bit rise, fall;
    exp_v = '0;
    if (in_reset) begin
      m_pq = 0; m_first = 0; m_armed = 0; m_longdone = 0;
    end else begin
      rise = p && !m_pq;
      fall = !p && m_pq;
      exp_v[5] = rise;
      exp_v[4] = fall;
      exp_v[0] = p;
      if (rise) begin
        exp_v[1]   = m_armed;
        m_first    = !m_armed;
        m_armed    = 0;
        m_longdone = 0;
        m_tp       = cyc;
      end else if (fall) begin
        if (m_first && !m_longdone) begin
          m_armed = 1;
          m_tr    = cyc;
        end
        m_first = 0;
      end else if (p && m_first && !m_longdone && (cyc - m_tp) == L) begin
        exp_v[2]   = 1'b1;
        m_longdone = 1;
      end
      if (!rise && m_armed && (cyc - m_tr) == G) begin
        exp_v[3] = 1'b1;
        m_armed  = 0;
      end
      m_pq = p;
    end
  endtask

  task automatic step(input bit p);
    logic [5:0] got_h, got_l;
    sig_h = p;
    sig_l = ~p;
    @(posedge clk);
    cyc++;
    model_step(p, !rstn);
    #1;
    got_h = {ph, rh, sh, lh, dh, hh};
    got_l = {pl, rl, sl, ll, dl, hl};
    chk_vec("outs_active_high", got_h, exp_v);
    chk_vec("outs_active_low", got_l, exp_v);
    chk("pulse_exclusive", int'(sh) + int'(lh) + int'(dh) <= 1, 1);
    if (ph && t_press < 0) t_press = cyc;
    if (rh && t_rel < 0) t_rel = cyc;
    if (lh && t_long < 0) t_long = cyc;
    if (sh && t_short < 0) t_short = cyc;
    n_short  += int'(sh);
    n_long   += int'(lh);
    n_double += int'(dh);
  endtask

  task automatic clear_stats();
    t_press = -1; t_rel = -1; t_long = -1; t_short = -1;
    n_short = 0; n_long = 0; n_double = 0;
  endtask

  initial begin
    tbl[0] = '{h1: 5,  gap: 40, h2: 0, n_short: 1, n_long: 0, n_double: 0, long_off: -1, short_off: 10};
    tbl[1] = '{h1: 30, gap: 40, h2: 0, n_short: 0, n_long: 1, n_double: 0, long_off: 20, short_off: -1};
    tbl[2] = '{h1: 5,  gap: 4,  h2: 5, n_short: 0, n_long: 0, n_double: 1, long_off: -1, short_off: -1};
    tbl[3] = '{h1: 5,  gap: 11, h2: 5, n_short: 2, n_long: 0, n_double: 0, long_off: -1, short_off: 10};
    tbl[4] = '{h1: 5,  gap: 10, h2: 5, n_short: 0, n_long: 0, n_double: 1, long_off: -1, short_off: -1};
    tbl[5] = '{h1: 20, gap: 40, h2: 0, n_short: 1, n_long: 0, n_double: 0, long_off: -1, short_off: 10};
    tbl[6] = '{h1: 21, gap: 40, h2: 0, n_short: 0, n_long: 1, n_double: 0, long_off: 20, short_off: -1};
    tbl[7] = '{h1: 1,  gap: 1,  h2: 1, n_short: 0, n_long: 0, n_double: 1, long_off: -1, short_off: -1};
    clear_stats();

    // reset state, including a pressed input held while in reset
    step(0);
    step(1);
    step(0);
    rstn = 1'b1;
    step(0);
    step(0);

    foreach (tbl[i]) begin
      clear_stats();
      for (int k = 0; k < tbl[i].h1; k++) step(1);
      for (int k = 0; k < tbl[i].gap; k++) step(0);
      for (int k = 0; k < tbl[i].h2; k++) step(1);
      for (int k = 0; k < 40; k++) step(0);
      chk($sformatf("tbl%0d_n_short", i), n_short, tbl[i].n_short);
      chk($sformatf("tbl%0d_n_long", i), n_long, tbl[i].n_long);
      chk($sformatf("tbl%0d_n_double", i), n_double, tbl[i].n_double);
      chk($sformatf("tbl%0d_long_off", i), (t_long < 0) ? -1 : t_long - t_press, tbl[i].long_off);
      chk($sformatf("tbl%0d_short_off", i), (t_short < 0) ? -1 : t_short - t_rel, tbl[i].short_off);
    end

    // reset while in PRESS1, released with the button still down
    clear_stats();
    for (int k = 0; k < 5; k++) step(1);
    rstn = 1'b0;
    #1;
    chk_vec("async_reset_press1_h", {ph, rh, sh, lh, dh, hh}, 6'b0);
    chk_vec("async_reset_press1_l", {pl, rl, sl, ll, dl, hl}, 6'b0);
    step(1);
    step(1);
    rstn = 1'b1;
    clear_stats();
    step(1);
    chk("press_after_reset", t_press, cyc);
    for (int k = 0; k < 4; k++) step(1);

    // reset while in WAIT2: the pending short must be discarded
    step(0);
    step(0);
    step(0);
    rstn = 1'b0;
    #1;
    chk_vec("async_reset_wait2_h", {ph, rh, sh, lh, dh, hh}, 6'b0);
    step(0);
    rstn = 1'b1;
    clear_stats();
    for (int k = 0; k < 2 * G; k++) step(0);
    chk("no_short_after_reset", n_short, 0);

    // randomized run lengths mixed with every-cycle toggling
    for (int r = 0; r < 120; r++) begin
      bit lvl;
      int len;
      lvl = r[0];
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < 16; k++) step(k[0]);
      end else begin
        len = $urandom_range(1, 26);
        for (int k = 0; k < len; k++) step(lvl);
      end
    end
    for (int k = 0; k < 40; k++) step(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
